// File: rtl/hazard_stall_ctrl_if.sv
// Decode-stage hazard signals between the pipeline datapath and the stall scheduler.
// The master is the pipeline side, which supplies the hazard fields; the slave is the scheduler, which returns the enables.
interface hazard_stall_ctrl_if;
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_rs_tuse;
  logic [1:0] D_rt_tuse;
  logic       D_is_md;
  logic [4:0] E_A3;
  logic [1:0] E_tnew;
  logic [4:0] M_A3;
  logic [1:0] M_tnew;
  logic       E_md_start;
  logic       E_md_div;
  logic       PC_WE;
  logic       D_WE;
  logic       E_clr;
  logic       md_busy;

  modport master (
    output D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_is_md,
    output E_A3, E_tnew, M_A3, M_tnew, E_md_start, E_md_div,
    input  PC_WE, D_WE, E_clr, md_busy
  );

  modport slave (
    input  D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_is_md,
    input  E_A3, E_tnew, M_A3, M_tnew, E_md_start, E_md_div,
    output PC_WE, D_WE, E_clr, md_busy
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage stall scheduler: register tuse/tnew hazards plus the mult/div busy countdown.
// Stall outputs are combinational, so a hazard holds F/D in the same cycle it is presented.
module hazard_stall_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input logic clk,
  input logic reset,
  hazard_stall_ctrl_if.slave hz
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             busy;
  logic             stall_rs;
  logic             stall_rt;
  logic             stall_md;
  logic             stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  // A start that arrives while the unit is already counting is ignored.
  always_comb begin
    cnt_nxt = cnt;
    if (cnt == '0) begin
      if (hz.E_md_start) begin
        cnt_nxt = hz.E_md_div ? DIV_LD : MULT_LD;
      end
    end else begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

  always_comb begin
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    stall_md = 1'b0;
    stall    = 1'b0;
    // A hazard stalls only when the producer's result arrives after the consumer needs it.
    // When tnew <= tuse, forwarding resolves the hazard instead.
    if (hz.D_rs != 5'd0) begin
      stall_rs = ((hz.D_rs == hz.E_A3) && (hz.E_tnew > hz.D_rs_tuse)) ||
                 ((hz.D_rs == hz.M_A3) && (hz.M_tnew > hz.D_rs_tuse));
    end
    if (hz.D_rt != 5'd0) begin
      stall_rt = ((hz.D_rt == hz.E_A3) && (hz.E_tnew > hz.D_rt_tuse)) ||
                 ((hz.D_rt == hz.M_A3) && (hz.M_tnew > hz.D_rt_tuse));
    end
    stall_md = hz.D_is_md && (hz.E_md_start || busy);
    if (!reset) begin
      stall = stall_rs || stall_rt || stall_md;
    end
  end

  assign hz.PC_WE   = ~stall;
  assign hz.D_WE    = ~stall;
  assign hz.E_clr   = stall;
  assign hz.md_busy = busy;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-number model of the hazard and MD-busy rules.
module tb_hazard_stall_ctrl;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  hazard_stall_ctrl_if bus ();

  hazard_stall_ctrl #(
    .MULT_CYC(MULT_CYC),
    .DIV_CYC (DIV_CYC),
    .CNT_W   (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.D_rs = 0; bus.D_rt = 0; bus.D_rs_tuse = 3; bus.D_rt_tuse = 3; bus.D_is_md = 0;
    bus.E_A3 = 0; bus.E_tnew = 0; bus.M_A3 = 0; bus.M_tnew = 0;
    bus.E_md_start = 0; bus.E_md_div = 0;
  endtask

  // The producer's value is ready tnew cycles from now; the consumer needs it tuse cycles from now.
  function automatic bit late_operand(input int r, input int tuse, input int dst, input int tnew);
    int ready_at;
    int needed_at;
    ready_at  = tnew;
    needed_at = tuse;
    return (r != 0) && (r == dst) && (ready_at > needed_at);
  endfunction

  task automatic test_reset();
    logic [2:0] got;
    reset = 1'b1;
    idle();
    bus.E_A3 = 8; bus.E_tnew = 2; bus.D_rs = 8; bus.D_rs_tuse = 0; bus.D_is_md = 1;
    #1;
    got = {bus.PC_WE, bus.D_WE, bus.E_clr};
    n_checks++;
    if (got !== 3'b110) begin
      n_fail++; $display("FAIL reset_ctl got %b exp 110", got);
    end
    next_cycle();
    reset = 1'b0;
    idle();
    #1;
    n_checks++;
    if (bus.md_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_md_busy got %b exp 0", bus.md_busy);
    end
    got = {bus.PC_WE, bus.D_WE, bus.E_clr};
    n_checks++;
    if (got !== 3'b110) begin
      n_fail++; $display("FAIL post_reset_ctl got %b exp 110", got);
    end
  endtask

  task automatic test_load_use();
    logic [2:0] got;
    next_cycle();
    idle();
    bus.E_A3 = 8; bus.E_tnew = 2; bus.D_rs = 8; bus.D_rs_tuse = 0;
    #1;
    got = {bus.PC_WE, bus.D_WE, bus.E_clr};
    n_checks++;
    if (got !== 3'b001) begin
      n_fail++; $display("FAIL load_use_stall got %b exp 001", got);
    end
    bus.D_rs_tuse = 1; bus.E_tnew = 1;
    #1;
    got = {bus.PC_WE, bus.D_WE, bus.E_clr};
    n_checks++;
    if (got !== 3'b110) begin
      n_fail++; $display("FAIL load_use_fwd got %b exp 110", got);
    end
    bus.E_tnew = 2;
    #1;
    got = {bus.PC_WE, bus.D_WE, bus.E_clr};
    n_checks++;
    if (got !== 3'b001) begin
      n_fail++; $display("FAIL load_use_tuse1 got %b exp 001", got);
    end
  endtask

  task automatic test_zero_unused();
    logic [2:0] got;
    next_cycle();
    idle();
    bus.E_A3 = 0; bus.D_rs = 0; bus.E_tnew = 2; bus.D_rs_tuse = 0;
    #1;
    got = {bus.PC_WE, bus.D_WE, bus.E_clr};
    n_checks++;
    if (got !== 3'b110) begin
      n_fail++; $display("FAIL zero_reg got %b exp 110", got);
    end
    bus.D_rs = 0; bus.D_rt = 9; bus.E_A3 = 9; bus.D_rt_tuse = 3;
    #1;
    got = {bus.PC_WE, bus.D_WE, bus.E_clr};
    n_checks++;
    if (got !== 3'b110) begin
      n_fail++; $display("FAIL unused_rt got %b exp 110", got);
    end
    bus.D_rt_tuse = 0;
    #1;
    got = {bus.PC_WE, bus.D_WE, bus.E_clr};
    n_checks++;
    if (got !== 3'b001) begin
      n_fail++; $display("FAIL rt_e_hazard got %b exp 001", got);
    end
  endtask

  task automatic test_m_hazard();
    logic [2:0] got;
    next_cycle();
    idle();
    bus.M_A3 = 4; bus.M_tnew = 1; bus.D_rt = 4; bus.D_rt_tuse = 0;
    #1;
    got = {bus.PC_WE, bus.D_WE, bus.E_clr};
    n_checks++;
    if (got !== 3'b001) begin
      n_fail++; $display("FAIL m_hazard got %b exp 001", got);
    end
    bus.M_tnew = 0;
    #1;
    got = {bus.PC_WE, bus.D_WE, bus.E_clr};
    n_checks++;
    if (got !== 3'b110) begin
      n_fail++; $display("FAIL m_fwd got %b exp 110", got);
    end
  endtask

  task automatic test_mult_timing();
    logic [2:0] got;
    logic       exp_stall;
    logic       exp_busy;
    for (int k = 0; k <= 7; k++) begin
      next_cycle();
      idle();
      bus.D_is_md    = 1;
      bus.E_md_start = (k == 0);
      bus.E_md_div   = 0;
      #1;
      exp_busy  = (k >= 1) && (k <= MULT_CYC);
      exp_stall = (k <= MULT_CYC);
      n_checks++;
      if (bus.md_busy !== exp_busy) begin
        n_fail++; $display("FAIL mult_busy k=%0d got %b exp %b", k, bus.md_busy, exp_busy);
      end
      got = {bus.PC_WE, bus.D_WE, bus.E_clr};
      n_checks++;
      if (got !== {~exp_stall, ~exp_stall, exp_stall}) begin
        n_fail++; $display("FAIL mult_stall k=%0d got %b exp stall=%b", k, got, exp_stall);
      end
    end
  endtask

  task automatic test_div_timing();
    logic [2:0] got;
    logic       exp_busy;
    for (int k = 0; k <= 12; k++) begin
      next_cycle();
      idle();
      bus.D_is_md    = 0;
      bus.E_md_start = (k == 0);
      bus.E_md_div   = 1;
      #1;
      exp_busy = (k >= 1) && (k <= DIV_CYC);
      n_checks++;
      if (bus.md_busy !== exp_busy) begin
        n_fail++; $display("FAIL div_busy k=%0d got %b exp %b", k, bus.md_busy, exp_busy);
      end
      got = {bus.PC_WE, bus.D_WE, bus.E_clr};
      n_checks++;
      if (got !== 3'b110) begin
        n_fail++; $display("FAIL div_nonmd_stall k=%0d got %b exp 110", k, got);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [2:0] got;
    logic       exp_busy;
    for (int k = 0; k <= 3; k++) begin
      next_cycle();
      idle();
      bus.E_md_start = (k == 0);
      bus.E_md_div   = 1;
    end
    next_cycle();
    idle();
    #1;
    n_checks++;
    if (bus.md_busy !== 1'b1) begin
      n_fail++; $display("FAIL midop_busy_before got %b exp 1", bus.md_busy);
    end
    reset = 1'b1;
    bus.D_is_md = 1;
    #1;
    got = {bus.PC_WE, bus.D_WE, bus.E_clr};
    n_checks++;
    if (got !== 3'b110) begin
      n_fail++; $display("FAIL midop_reset_ctl got %b exp 110", got);
    end
    for (int k = 0; k <= 6; k++) begin
      next_cycle();
      reset = 1'b0;
      idle();
      bus.E_md_start = (k == 0);
      bus.E_md_div   = 0;
      #1;
      exp_busy = (k >= 1) && (k <= MULT_CYC);
      n_checks++;
      if (bus.md_busy !== exp_busy) begin
        n_fail++; $display("FAIL midop_busy k=%0d got %b exp %b", k, bus.md_busy, exp_busy);
      end
    end
  endtask

  task automatic test_random(input int n);
    int         cyc;
    int         busy_end;
    bit         exp_busy;
    bit         exp_stall;
    bit         do_reset;
    logic [2:0] got;
    busy_end = -1;
    for (cyc = 0; cyc < n; cyc++) begin
      next_cycle();
      do_reset = (cyc == 0) || ($urandom_range(0, 39) == 0);
      reset = do_reset;
      bus.D_rs      = 5'($urandom_range(0, 3));
      bus.D_rt      = 5'($urandom_range(0, 3));
      bus.D_rs_tuse = ($urandom_range(0, 2) == 2) ? 2'd3 : 2'($urandom_range(0, 1));
      bus.D_rt_tuse = ($urandom_range(0, 2) == 2) ? 2'd3 : 2'($urandom_range(0, 1));
      bus.D_is_md   = 1'($urandom_range(0, 1));
      bus.E_A3      = 5'($urandom_range(0, 3));
      bus.E_tnew    = 2'($urandom_range(0, 2));
      bus.M_A3      = 5'($urandom_range(0, 3));
      bus.M_tnew    = 2'($urandom_range(0, 1));
      bus.E_md_div  = 1'($urandom_range(0, 1));
      exp_busy      = (cyc <= busy_end);
      bus.E_md_start = !do_reset && !exp_busy && ($urandom_range(0, 3) == 0);
      #1;
      if (do_reset) begin
        exp_stall = 0;
      end else begin
        exp_stall = late_operand(bus.D_rs, bus.D_rs_tuse, bus.E_A3, bus.E_tnew) ||
                    late_operand(bus.D_rs, bus.D_rs_tuse, bus.M_A3, bus.M_tnew) ||
                    late_operand(bus.D_rt, bus.D_rt_tuse, bus.E_A3, bus.E_tnew) ||
                    late_operand(bus.D_rt, bus.D_rt_tuse, bus.M_A3, bus.M_tnew) ||
                    (bus.D_is_md && (bus.E_md_start || exp_busy));
        n_checks++;
        if (bus.md_busy !== exp_busy) begin
          n_fail++; $display("FAIL rand_busy cyc=%0d got %b exp %b", cyc, bus.md_busy, exp_busy);
        end
        n_checks++;
        if (bus.E_md_start && bus.md_busy) begin
          n_fail++; $display("FAIL rand_start_while_busy cyc=%0d got busy=%b exp 0", cyc, bus.md_busy);
        end
      end
      got = {bus.PC_WE, bus.D_WE, bus.E_clr};
      n_checks++;
      if (got !== {~exp_stall, ~exp_stall, exp_stall}) begin
        n_fail++; $display("FAIL rand_ctl cyc=%0d got %b exp stall=%b", cyc, got, exp_stall);
      end
      if (do_reset) begin
        busy_end = cyc;
      end else if (bus.E_md_start) begin
        busy_end = cyc + (bus.E_md_div ? DIV_CYC : MULT_CYC);
      end
    end
    next_cycle();
    reset = 1'b0;
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_zero_unused();
    test_m_hazard();
    test_mult_timing();
    test_div_timing();
    test_reset_mid_op();
    test_random(600);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Decode-stage hazard and stall scheduler for the 5-stage MIPS pipeline (F/D/E/M/W).
- Decides each cycle whether the fetch PC and the D-stage register may advance. Drives the PC write enable (WE of the fetch PC register), the D-register write enable and the E-register clear.
- Owns the multiply/divide busy countdown. Instructions that depend on HI/LO or on the MD unit are held in D until the current mult/div completes.

Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu start.
- DIV_CYC, 10, busy cycles after a div/divu start.
- CNT_W, 4, countdown width; must satisfy 2^CNT_W > max(MULT_CYC, DIV_CYC).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all internal state.
- D_rs  in  5  rs register number of the instruction in D.
- D_rt  in  5  rt register number of the instruction in D.
- D_rs_tuse  in  2  cycles until D needs rs: 0 = in D, 1 = in E, 3 = unused.
- D_rt_tuse  in  2  same encoding for rt.
- D_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- E_A3  in  5  destination register of the E instruction (0 = none).
- E_tnew  in  2  cycles until the E result is available (0..2).
- M_A3  in  5  destination register of the M instruction.
- M_tnew  in  2  cycles until the M result is available (0..1).
- E_md_start  in  1  a mult/div is in E this cycle (1-cycle pulse).
- E_md_div  in  1  qualifies E_md_start: 1 = div/divu, 0 = mult/multu.
- PC_WE  out  1  fetch PC may load NPC.
- D_WE  out  1  F/D register may load.
- E_clr  out  1  insert a bubble into the D/E register.
- md_busy  out  1  MD countdown non-zero.

Behaviour:
- State: cnt[CNT_W-1:0]. On reset, cnt is cleared to 0.
- md_busy = (cnt != 0). md_busy is 0 from the first cycle after reset.
- Countdown, evaluated at each rising edge when reset is low:
  - If cnt == 0 and E_md_start = 1: cnt loads DIV_CYC if E_md_div = 1, else MULT_CYC.
  - Else if cnt != 0: cnt decrements by 1.
  - Else: cnt holds.
  - E_md_start while cnt != 0 is ignored. The stall logic makes it unreachable; the bench asserts that it never occurs.
- Busy timing: a start in cycle t gives md_busy = 1 in cycles t+1 .. t+N (N = MULT_CYC or DIV_CYC), and 0 in cycle t+N+1.
- Register-hazard stall, combinational. Ignore the whole term when the register is $0.
  - stall_rs = (D_rs != 0) & ((D_rs == E_A3 & E_tnew > D_rs_tuse) | (D_rs == M_A3 & M_tnew > D_rs_tuse)).
  - stall_rt: same form using D_rt and D_rt_tuse.
  - tuse = 3 never stalls, because tnew ≤ 2.
- MD stall, combinational: stall_md = D_is_md & (E_md_start | md_busy).
- stall = stall_rs | stall_rt | stall_md.
- Outputs: PC_WE = ~stall, D_WE = ~stall, E_clr = stall.
- While reset = 1, stall is forced to 0: PC_WE = 1, D_WE = 1, E_clr = 0. The pipeline registers reset themselves.
- No forwarding decisions are made here. A hazard where tnew ≤ tuse is resolved by forwarding and must not stall.
- Outputs are purely combinational from the inputs and cnt, so a stall takes effect in the same cycle the hazard is presented.
- Reset asserted mid-countdown: cnt = 0 after the edge, and md_busy drops the next cycle regardless of the remaining count.

Test Plan:
- Load-use: E_A3=8, E_tnew=2; D_rs=8, D_rs_tuse=0 -> PC_WE=0, D_WE=0, E_clr=1. Same hazard with D_rs_tuse=1 and E_tnew=1 -> no stall.
- $0 and unused operands: E_A3=0, D_rs=0, E_tnew=2 -> no stall. D_rt=9=E_A3 with D_rt_tuse=3 -> no stall.
- Mult timing: E_md_start=1, E_md_div=0 at cycle t -> md_busy=1 for exactly cycles t+1..t+5. With D_is_md=1 held, stall=1 in cycles t..t+5 and released in t+6.
- Div timing: E_md_start=1, E_md_div=1 -> md_busy high for exactly 10 cycles. A non-MD instruction in D (D_is_md=0) never stalls during that window.
- M-stage hazard: M_A3=4, M_tnew=1, D_rt=4, D_rt_tuse=0 -> stall. With M_tnew=0 -> no stall.
- Reset mid-op: reset pulsed 1 cycle at cnt=7 -> PC_WE=1 during reset; md_busy=0 the next cycle; a following E_md_start is accepted and busy lasts the full 5 cycles.
